cu_mc: RTL and testbench
========================

Name: cu_mc

Overview:
- Parametrised multi-cycle control unit for the mycpu datapath; next generation of the single-cycle-execute CU.
- Decodes the instruction register into datapath controls, as the previous CU did.
- Adds generic register-address width, memory wait states (mem_rdy), a counted multi-cycle shift (SHN), halt/resume, and illegal-opcode flagging.
- Sits between the IR/PC and the register file, function unit and memory/IO muxes.

Parameters:
- REG_AW, 3, register address width; instruction width INS_W = 7 + 3*REG_AW.
- RS_FW, 4, width of each zero-padded register-select field in rs_out; must be >= REG_AW.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset: asynchronous, active-low.
- ins_in, in, INS_W, instruction: opcode [INS_W-1:INS_W-7], DR, SA, SB fields (REG_AW each, MSB first).
- z_in, in, 1, zero flag. n_in, in, 1, negative flag.
- mem_rdy, in, 1, memory ready this cycle.
- go_in, in, 1, resume request from halt.
- il_out, out, 1, IR load.
- ps_out, out, 2, PC select: 00 hold, 01 inc, 10 branch, 11 jump.
- rw_out, out, 1, register write.
- rs_out, out, 3*RS_FW, {DR, SA, SB}, each zero-extended to RS_FW.
- mm_out, out, 1, memory address mux. md_out, out, 2, write-back mux: 00 FU, 01 mem, 10 IO.
- mb_out, out, 1, immediate select. fs_out, out, 4, function select.
- wen_out, out, 1, memory write enable, active-low.
- iom_out, out, 1, IO select. mem_req_out, out, 1, memory access in progress.
- halted_out, out, 1, in HLT. illegal_out, out, 1, one-cycle pulse on an undefined opcode.

Behaviour:
- Defaults in every state unless overridden: il=0, ps=00, rw=0, rs=0, mm=0, md=00, mb=0, fs=0000, wen=1, iom=0, mem_req=0, halted=0, illegal=0.
- Reset: state RST, cnt_r=0, all outputs at defaults. Reset mid-operation aborts immediately; no partial write completes.
- Outputs are combinational from state_r, cnt_r and inputs; state_r and cnt_r are the only registers.
- States and transitions:
  - RST -> INF.
  - INF: mem_req=1, il=mem_rdy. Stay in INF while mem_rdy=0; go to EX0 when mem_rdy=1.
  - EX0: decode ins_in.
    - rs = {DR, SA, SB}.
    - fs = opcode[3:0] for all opcodes except BRN (fs=0000).
    - mb=1 for LDI/ADI. md=01 for LD, 10 for IOR. iom=1 for IOR/IOW.
    - rw=1 except ST, BRZ, BRN, JMP, IOW, HAL, illegal.
    - ps=01 except: BRZ (10 if z_in=1, else 01); BRN (10 if n_in=1, else 01); JMP (11); HAL (00).
    - Next state INF except as follows.
  - LD/ST in EX0: mem_req=1. If mem_rdy=0, suppress side effects (rw=0, wen=1, ps=00) and go to MW. If mem_rdy=1, complete (LD rw=1; ST wen=0) and go to INF.
  - MW: same decode as EX0 (ins_in is held) with mem_req=1. Side effects only in the cycle mem_rdy=1, then INF. Wait is unbounded.
  - SHN:
    - Count = SB field. Count 0: ps=01, rw=0, go to INF.
    - Otherwise EX0 performs the first shift (rw=1, fs=1101) and loads cnt_r=count-1. If count=1: ps=01, go to INF; else ps=00, go to EXN.
  - EXN: rw=1, rs={DR, DR, SB}, fs=1101, ps=00, cnt_r decrements. When cnt_r=1: ps=01, go to INF. Total shifts = count.
  - HAL in EX0: go to HLT.
  - HLT: halted=1. On go_in=1: ps=01 for one cycle, go to INF; otherwise stay.
  - Illegal opcode in EX0: illegal=1, ps=01, no writes, go to INF.
- Simultaneous events: go_in outside HLT is ignored. mem_rdy outside INF/EX0/MW is ignored.
- cnt_r width is REG_AW. The count cannot wrap because the load is count-1 only when count>=1.

Decomposition:
- mycpu_pkg additions:
  - cu_mc_state_t {RST, INF, EX0, MW, EXN, HLT}.
  - opcode_t values (7-bit): MOVA 0000000, INC 0000001, ADD 0000010, SUB 0000101, AND 0001000, OR 0001001, XOR 0001010, NOT 0001011, MOVB 0001100, SHR 0001101, SHL 0001110, LD 0010000, IOR 0010001, SHN 0011101, ST 0100000, IOW 0100001, ADI 1000010, LDI 1001100, BRZ 1100000, BRN 1100001, JMP 1110000, HAL 1111111.
  - PS_* and MD_* constants.
- One sub-module, cu_mc_decode: combinational opcode-to-control-word decode, instantiated once and used by EX0 and MW.

Test Plan:
- Reset with rst_n low, then release, mem_rdy=1 -> RST, INF (il=1), EX0. Pulling rst_n low during EXN -> outputs return to defaults in the same cycle.
- ADD R3,R1,R2 (REG_AW=3) -> EX0 drives rs=0x312, fs=0010, rw=1, ps=01.
- LD with mem_rdy low for 3 cycles -> 3 MW cycles with rw=0, mem_req=1. mem_rdy=1 -> rw=1, md=01, ps=01, then INF.
- SHN R4,R4,count=5 -> exactly 5 cycles with rw=1, fs=1101. ps=01 only on the 5th. SHN with count=0 -> no write, ps=01.
- BRZ with z_in=1 -> ps=10; with z_in=0 -> ps=01. BRN with n_in=1 -> ps=10. JMP -> ps=11.
- HAL -> ps=00, HLT, halted=1 held for 10 cycles. go_in=1 -> ps=01 once, then INF. Opcode 1010101 -> illegal=1 pulse, no writes.

Source files
------------

// File: rtl/cu_mc_pkg.sv
// cu_mc shared types: states, opcodes,
// mux encodings and the decoded control word.
package cu_mc_pkg;

  typedef enum logic [2:0] {
    RST, INF, EX0, MW, EXN, HLT
  } cu_mc_state_t;

  typedef enum logic [6:0] {
    OP_MOVA = 7'b0000000,
    OP_INC  = 7'b0000001,
    OP_ADD  = 7'b0000010,
    OP_SUB  = 7'b0000101,
    OP_AND  = 7'b0001000,
    OP_OR   = 7'b0001001,
    OP_XOR  = 7'b0001010,
    OP_NOT  = 7'b0001011,
    OP_MOVB = 7'b0001100,
    OP_SHR  = 7'b0001101,
    OP_SHL  = 7'b0001110,
    OP_LD   = 7'b0010000,
    OP_IOR  = 7'b0010001,
    OP_SHN  = 7'b0011101,
    OP_ST   = 7'b0100000,
    OP_IOW  = 7'b0100001,
    OP_ADI  = 7'b1000010,
    OP_LDI  = 7'b1001100,
    OP_BRZ  = 7'b1100000,
    OP_BRN  = 7'b1100001,
    OP_JMP  = 7'b1110000,
    OP_HAL  = 7'b1111111
  } opcode_t;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_JMP  = 2'b11;

  localparam logic [1:0] MD_FU  = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;
  localparam logic [1:0] MD_IO  = 2'b10;

  localparam logic [3:0] FS_SHR = 4'b1101;

  typedef struct packed {
    logic [3:0] fs;
    logic       mb;
    logic [1:0] md;
    logic       iom;
    logic       rw;
    logic [1:0] ps;
    logic       wen;
    logic       mem;
    logic       shn;
    logic       hal;
    logic       ill;
  } ctrl_t;

endpackage

// File: rtl/cu_mc_if.sv
// cu_mc bundle: instruction/flags/handshake
// in, datapath control word out.
interface cu_mc_if #(
  parameter int REG_AW = 3,
  parameter int RS_FW  = 4
);
  localparam int INS_W = 7 + 3 * REG_AW;

  logic [INS_W-1:0]   ins_in;
  logic               z_in;
  logic               n_in;
  logic               mem_rdy;
  logic               go_in;
  logic               il_out;
  logic [1:0]         ps_out;
  logic               rw_out;
  logic [3*RS_FW-1:0] rs_out;
  logic               mm_out;
  logic [1:0]         md_out;
  logic               mb_out;
  logic [3:0]         fs_out;
  logic               wen_out;
  logic               iom_out;
  logic               mem_req_out;
  logic               halted_out;
  logic               illegal_out;

  modport master (
    input  ins_in, z_in, n_in,
    input  mem_rdy, go_in,
    output il_out, ps_out, rw_out,
    output rs_out, mm_out, md_out,
    output mb_out, fs_out, wen_out,
    output iom_out, mem_req_out,
    output halted_out, illegal_out
  );

  modport slave (
    output ins_in, z_in, n_in,
    output mem_rdy, go_in,
    input  il_out, ps_out, rw_out,
    input  rs_out, mm_out, md_out,
    input  mb_out, fs_out, wen_out,
    input  iom_out, mem_req_out,
    input  halted_out, illegal_out
  );
endinterface

// File: rtl/cu_mc_decode.sv
// Opcode to control word, shared by the
// execute and memory-wait states.
import cu_mc_pkg::*;

module cu_mc_decode (
  input  logic [6:0] op_i,
  input  logic       z_i,
  input  logic       n_i,
  output ctrl_t      ctrl_o
);

  // ALU ops write back and step the PC
  always_comb begin
    ctrl_o     = '0;
    ctrl_o.fs  = op_i[3:0];
    ctrl_o.rw  = 1'b1;
    ctrl_o.ps  = PS_INC;
    ctrl_o.wen = 1'b1;
    unique case (op_i)
      OP_MOVA, OP_INC, OP_ADD, OP_SUB,
      OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_MOVB, OP_SHR, OP_SHL: ;
      OP_ADI, OP_LDI: ctrl_o.mb = 1'b1;
      OP_LD: begin
        ctrl_o.md  = MD_MEM;
        ctrl_o.mem = 1'b1;
      end
      OP_ST: begin
        ctrl_o.rw  = 1'b0;
        ctrl_o.wen = 1'b0;
        ctrl_o.mem = 1'b1;
      end
      OP_IOR: begin
        ctrl_o.md  = MD_IO;
        ctrl_o.iom = 1'b1;
      end
      OP_IOW: begin
        ctrl_o.rw  = 1'b0;
        ctrl_o.iom = 1'b1;
      end
      OP_SHN: ctrl_o.shn = 1'b1;
      OP_BRZ: begin
        ctrl_o.rw = 1'b0;
        ctrl_o.ps = z_i ? PS_BR : PS_INC;
      end
      OP_BRN: begin
        ctrl_o.rw = 1'b0;
        ctrl_o.fs = 4'b0000;
        ctrl_o.ps = n_i ? PS_BR : PS_INC;
      end
      OP_JMP: begin
        ctrl_o.rw = 1'b0;
        ctrl_o.ps = PS_JMP;
      end
      OP_HAL: begin
        ctrl_o.rw  = 1'b0;
        ctrl_o.ps  = PS_HOLD;
        ctrl_o.hal = 1'b1;
      end
      default: begin
        ctrl_o.rw  = 1'b0;
        ctrl_o.ill = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cu_mc.sv
// Multi-cycle control unit: fetch, execute,
// memory wait, counted shift, halt.
import cu_mc_pkg::*;

module cu_mc #(
  parameter int REG_AW = 3,
  parameter int RS_FW  = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  cu_mc_if.master bus
);

  localparam int INS_W = 7 + 3 * REG_AW;

  cu_mc_state_t      state_q, state_d;
  logic [REG_AW-1:0] cnt_q, cnt_d;

  logic [6:0]        op;
  logic [REG_AW-1:0] dr, sa, sb;
  ctrl_t             c;

  logic               il, rw, mb, wen;
  logic               iom, mreq, halted, ill;
  logic [1:0]         ps, md;
  logic [3:0]         fs;
  logic [3*RS_FW-1:0] rs;

  assign op = bus.ins_in[INS_W-1 -: 7];
  assign dr = bus.ins_in[3*REG_AW-1 -: REG_AW];
  assign sa = bus.ins_in[2*REG_AW-1 -: REG_AW];
  assign sb = bus.ins_in[REG_AW-1:0];

  cu_mc_decode u_dec (
    .op_i   (op),
    .z_i    (bus.z_in),
    .n_i    (bus.n_in),
    .ctrl_o (c)
  );

  // state and shift counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state and control outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    il      = 1'b0;
    ps      = PS_HOLD;
    rw      = 1'b0;
    rs      = '0;
    md      = MD_FU;
    mb      = 1'b0;
    fs      = 4'b0000;
    wen     = 1'b1;
    iom     = 1'b0;
    mreq    = 1'b0;
    halted  = 1'b0;
    ill     = 1'b0;
    unique case (state_q)
      RST: state_d = INF;
      INF: begin
        mreq = 1'b1;
        il   = bus.mem_rdy;
        if (bus.mem_rdy) state_d = EX0;
      end
      EX0, MW: begin
        rs = {RS_FW'(dr), RS_FW'(sa),
              RS_FW'(sb)};
        fs = c.fs;
        mb = c.mb;
        md = c.md;
        iom = c.iom;
        rw = c.rw;
        ps = c.ps;
        state_d = INF;
        unique case (1'b1)
          c.mem: begin
            mreq = 1'b1;
            if (bus.mem_rdy) begin
              wen = c.wen;
            end else begin
              rw = 1'b0;
              ps = PS_HOLD;
              state_d = MW;
            end
          end
          c.shn: begin
            if (sb == '0) begin
              rw = 1'b0;
            end else begin
              cnt_d = sb - REG_AW'(1);
              if (sb != REG_AW'(1)) begin
                ps = PS_HOLD;
                state_d = EXN;
              end
            end
          end
          c.hal: state_d = HLT;
          c.ill: ill = 1'b1;
          default: ;
        endcase
      end
      EXN: begin
        rw = 1'b1;
        rs = {RS_FW'(dr), RS_FW'(dr),
              RS_FW'(sb)};
        fs = FS_SHR;
        cnt_d = cnt_q - REG_AW'(1);
        if (cnt_q == REG_AW'(1)) begin
          ps = PS_INC;
          state_d = INF;
        end
      end
      HLT: begin
        halted = 1'b1;
        if (bus.go_in) begin
          ps = PS_INC;
          state_d = INF;
        end
      end
      default: state_d = RST;
    endcase
  end

  assign bus.il_out      = il;
  assign bus.ps_out      = ps;
  assign bus.rw_out      = rw;
  assign bus.rs_out      = rs;
  assign bus.mm_out      = 1'b0;
  assign bus.md_out      = md;
  assign bus.mb_out      = mb;
  assign bus.fs_out      = fs;
  assign bus.wen_out     = wen;
  assign bus.iom_out     = iom;
  assign bus.mem_req_out = mreq;
  assign bus.halted_out  = halted;
  assign bus.illegal_out = ill;

endmodule

// File: tb/tb_cu_mc.sv
// Directed bench for cu_mc with a queue of
// expected control words per cycle.
import cu_mc_pkg::*;

module tb_cu_mc;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  cu_mc_if #(.REG_AW(3), .RS_FW(4)) bus ();

  cu_mc #(.REG_AW(3), .RS_FW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [28:0] obs;
  assign obs = {bus.il_out, bus.ps_out,
                bus.rw_out, bus.rs_out,
                bus.mm_out, bus.md_out,
                bus.mb_out, bus.fs_out,
                bus.wen_out, bus.iom_out,
                bus.mem_req_out,
                bus.halted_out,
                bus.illegal_out};

  logic [28:0] exp_q[$];
  string       tag_q[$];

  function automatic logic [28:0] mk(
    input logic       il,
    input logic [1:0] ps,
    input logic       rw,
    input logic [11:0] rs,
    input logic [1:0] md,
    input logic       mb,
    input logic [3:0] fs,
    input logic       wen,
    input logic       iom,
    input logic       mreq,
    input logic       hlt,
    input logic       ill
  );
    return {il, ps, rw, rs, 1'b0, md, mb,
            fs, wen, iom, mreq, hlt, ill};
  endfunction

  function automatic logic [28:0] infv(
    input logic rdy
  );
    return mk(rdy, 2'b00, 1'b0, 12'h000,
              2'b00, 1'b0, 4'h0, 1'b1,
              1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic logic [15:0] ins(
    input logic [6:0] op,
    input logic [2:0] d,
    input logic [2:0] a,
    input logic [2:0] b
  );
    return {op, d, a, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [28:0] e,
                     input string t);
    logic [28:0] x;
    string       s;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(negedge clk);
    x = exp_q.pop_front();
    s = tag_q.pop_front();
    checks++;
    assert (obs === x) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             s, obs, x);
    end
  endtask

  logic [28:0] dflt, shn_ex, shn_n, shn_l;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    dflt = mk(0, 2'b00, 0, 12'h000, 2'b00, 0,
              4'h0, 1, 0, 0, 0, 0);
    rst_n = 1'b0;
    bus.ins_in = '0;
    bus.z_in = 1'b0;
    bus.n_in = 1'b0;
    bus.mem_rdy = 1'b0;
    bus.go_in = 1'b0;

    tick(); chk(dflt, "reset");
    tick(); rst_n = 1'b1; bus.mem_rdy = 1'b1;
    bus.ins_in = ins(OP_ADD, 3, 1, 2);
    chk(dflt, "rst_state");
    tick(); chk(infv(1), "inf_fetch");
    tick();
    chk(mk(0, 2'b01, 1, 12'h312, 2'b00, 0,
           4'h2, 1, 0, 0, 0, 0), "add");

    tick(); bus.ins_in = ins(OP_LD, 5, 2, 0);
    chk(infv(1), "inf_ld");
    tick(); bus.mem_rdy = 1'b0;
    chk(mk(0, 2'b00, 0, 12'h520, 2'b01, 0,
           4'h0, 1, 0, 1, 0, 0), "ld_ex0_wait");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk(mk(0, 2'b00, 0, 12'h520, 2'b01, 0,
             4'h0, 1, 0, 1, 0, 0), "ld_mw_wait");
    end
    tick(); bus.mem_rdy = 1'b1;
    chk(mk(0, 2'b01, 1, 12'h520, 2'b01, 0,
           4'h0, 1, 0, 1, 0, 0), "ld_done");
    tick(); bus.mem_rdy = 1'b0;
    chk(infv(0), "inf_wait");
    tick(); bus.mem_rdy = 1'b1;
    bus.ins_in = ins(OP_ST, 0, 1, 2);
    chk(infv(1), "inf_st");
    tick();
    chk(mk(0, 2'b01, 0, 12'h012, 2'b00, 0,
           4'h0, 0, 0, 1, 0, 0), "st");

    tick(); bus.ins_in = ins(OP_SHN, 4, 2, 5);
    chk(infv(1), "inf_shn");
    shn_ex = mk(0, 2'b00, 1, 12'h425, 2'b00, 0,
                4'hD, 1, 0, 0, 0, 0);
    shn_n = mk(0, 2'b00, 1, 12'h445, 2'b00, 0,
               4'hD, 1, 0, 0, 0, 0);
    shn_l = mk(0, 2'b01, 1, 12'h445, 2'b00, 0,
               4'hD, 1, 0, 0, 0, 0);
    tick(); chk(shn_ex, "shn_ex0");
    for (int i = 0; i < 3; i++) begin
      tick(); chk(shn_n, "shn_exn");
    end
    tick(); chk(shn_l, "shn_last");
    tick(); bus.ins_in = ins(OP_SHN, 1, 1, 0);
    chk(infv(1), "inf_shn0");
    tick();
    chk(mk(0, 2'b01, 0, 12'h110, 2'b00, 0,
           4'hD, 1, 0, 0, 0, 0), "shn_cnt0");
    tick(); bus.ins_in = ins(OP_SHN, 2, 3, 1);
    chk(infv(1), "inf_shn1");
    tick();
    chk(mk(0, 2'b01, 1, 12'h231, 2'b00, 0,
           4'hD, 1, 0, 0, 0, 0), "shn_cnt1");

    tick(); bus.ins_in = ins(OP_BRZ, 0, 3, 0);
    bus.z_in = 1'b1;
    chk(infv(1), "inf_brz");
    tick();
    chk(mk(0, 2'b10, 0, 12'h030, 2'b00, 0,
           4'h0, 1, 0, 0, 0, 0), "brz_taken");
    tick(); bus.z_in = 1'b0;
    chk(infv(1), "inf_brz2");
    tick();
    chk(mk(0, 2'b01, 0, 12'h030, 2'b00, 0,
           4'h0, 1, 0, 0, 0, 0), "brz_not");
    tick(); bus.ins_in = ins(OP_BRN, 0, 3, 0);
    bus.n_in = 1'b1;
    chk(infv(1), "inf_brn");
    tick();
    chk(mk(0, 2'b10, 0, 12'h030, 2'b00, 0,
           4'h0, 1, 0, 0, 0, 0), "brn_taken");
    tick(); bus.ins_in = ins(OP_JMP, 0, 3, 0);
    bus.n_in = 1'b0; bus.go_in = 1'b1;
    chk(infv(1), "inf_go_ignored");
    tick(); bus.go_in = 1'b0;
    chk(mk(0, 2'b11, 0, 12'h030, 2'b00, 0,
           4'h0, 1, 0, 0, 0, 0), "jmp");
    tick(); bus.ins_in = ins(OP_IOR, 6, 1, 0);
    chk(infv(1), "inf_ior");
    tick();
    chk(mk(0, 2'b01, 1, 12'h610, 2'b10, 0,
           4'h1, 1, 1, 0, 0, 0), "ior");

    tick(); bus.ins_in = ins(OP_HAL, 0, 0, 0);
    chk(infv(1), "inf_hal");
    tick();
    chk(mk(0, 2'b00, 0, 12'h000, 2'b00, 0,
           4'hF, 1, 0, 0, 0, 0), "hal");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk(mk(0, 2'b00, 0, 12'h000, 2'b00, 0,
             4'h0, 1, 0, 0, 1, 0), "hlt_hold");
    end
    tick(); bus.go_in = 1'b1;
    chk(mk(0, 2'b01, 0, 12'h000, 2'b00, 0,
           4'h0, 1, 0, 0, 1, 0), "hlt_go");
    tick(); bus.go_in = 1'b0;
    bus.ins_in = ins(7'b1010101, 1, 2, 3);
    chk(infv(1), "inf_after_go");
    tick();
    chk(mk(0, 2'b01, 0, 12'h123, 2'b00, 0,
           4'h5, 1, 0, 0, 0, 1), "illegal");
    tick(); bus.ins_in = ins(OP_SHN, 4, 4, 5);
    chk(infv(1), "inf_after_ill");

    tick();
    chk(mk(0, 2'b00, 1, 12'h445, 2'b00, 0,
           4'hD, 1, 0, 0, 0, 0), "shn2_ex0");
    tick(); chk(shn_n, "shn2_exn");
    tick(); rst_n = 1'b0;
    chk(dflt, "rst_in_exn");
    tick(); rst_n = 1'b1;
    chk(dflt, "rst_exn_state");
    tick(); chk(infv(1), "inf_after_rst");

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
